// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use stall, branch flush and memory-wait FSM.
// Optional performance counters (stall_cnt/flush_cnt) are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 0,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              load_e,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              pcsrc_e,
  input  logic              mem_req_m,
  output logic [1:0]        forward_ae,
  output logic [1:0]        forward_be,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic              mem_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_e;

  localparam bit         LAT_EN = (MEM_LAT != 0);
  localparam logic [3:0] LAT_M1 = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mem_wait_s;
  logic       load_use_s;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rdm, input logic wm,
                                         input logic [REG_AW-1:0] rdw, input logic ww);
    logic [1:0] sel;
    if (wm && (rdm != '0) && (rdm == rs)) begin
      sel = 2'b10;
    end else if (ww && (rdw != '0) && (rdw == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt counts the remaining wait cycles after the one currently being stalled
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req_m && LAT_EN) begin
          cnt_d   = LAT_M1;
          state_d = (MEM_LAT == 1) ? S_DONE : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_wait_s = ((state_q == S_IDLE) && mem_req_m && LAT_EN) || (state_q == S_WAIT);
  assign load_use_s = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // Priority: reset > memory wait > taken branch > load-use
  always_comb begin
    forward_ae = 2'b00;
    forward_be = 2'b00;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_w    = 1'b0;
    mem_busy   = 1'b0;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else begin
      forward_ae = fwd_sel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
      forward_be = fwd_sel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
      if (mem_wait_s) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        stall_m  = 1'b1;
        flush_w  = 1'b1;
        mem_busy = 1'b1;
      end else if (pcsrc_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use_s) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        stall_f = 1'b0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if ((flush_d || flush_e) && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL provide parameter REG_AW, 5, register-address width.
REQ-002 SHALL provide parameter MEM_LAT, 0, data-memory wait cycles per load/store (range 0..15; 0 means single-cycle memory).
REQ-003 SHALL provide parameter CNT_W, 32, performance-counter width.
REQ-004 SHALL have the following ports:
  clk  in  1  sole clock, rising edge.
  reset  in  1  synchronous, active-high reset.
  rs1_d, rs2_d  in  REG_AW  decode-stage source registers.
  rs1_e, rs2_e  in  REG_AW  execute-stage source registers.
  rd_e, rd_m, rd_w  in  REG_AW  destination registers in E/M/W.
  load_e  in  1  instruction in E is a load.
  regwrite_m, regwrite_w  in  1  register write enables in M/W.
  pcsrc_e  in  1  taken branch or jump resolved in E.
  mem_req_m  in  1  load/store occupying M.
  forward_ae, forward_be  out  2  operand select: 00 register file, 01 W result, 10 M ALU result.
  stall_f, stall_d, stall_e, stall_m  out  1  hold the F/D/E/M pipeline registers.
  flush_d, flush_e, flush_w  out  1  insert a bubble into the D/E/W registers.
  mem_busy  out  1  memory wait in progress.
  stall_cnt, flush_cnt  out  CNT_W  performance counters; present only under REQ-021.

Function
REQ-005 SHALL set forward_ae=10 when regwrite_m, rd_m!=0, and rd_m==rs1_e; otherwise 01 when regwrite_w, rd_w!=0, and rd_w==rs1_e; otherwise 00. Forward_be SHALL follow the same rule using rs2_e. M SHALL take priority over W.
REQ-006 SHALL compute forwarding combinationally in every cycle, including memory-wait cycles.
REQ-007 SHALL flag a load-use hazard when load_e, rd_e!=0, and rd_e equals rs1_d or rs2_d. The response SHALL be a one-cycle assertion of stall_f, stall_d, and flush_e.
REQ-008 SHALL assert flush_d and flush_e in the same cycle when pcsrc_e=1. In that cycle the load-use stall SHALL be suppressed because the D instruction is squashed.
REQ-009 SHALL implement a memory-wait FSM with states IDLE, WAIT, and DONE, plus a 4-bit counter cnt.
REQ-010 In IDLE with mem_req_m=1 and MEM_LAT>0, the FSM SHALL assert the wait stalls in that same cycle and load cnt<=MEM_LAT-1. The next state SHALL be DONE if MEM_LAT==1, otherwise WAIT.
REQ-011 In WAIT, the FSM SHALL assert the wait stalls and set cnt<=cnt-1. It SHALL move to DONE when cnt==1.
REQ-012 In DONE, the FSM SHALL assert no wait stalls, ignore mem_req_m, and return to IDLE after one cycle. The stall total per access SHALL therefore be exactly MEM_LAT cycles.
REQ-013 "Wait stalls" SHALL mean stall_f, stall_d, stall_e, stall_m, flush_w, and mem_busy all equal to 1.
REQ-014 When MEM_LAT==0, the FSM SHALL remain in IDLE permanently and mem_busy SHALL be constantly 0.
REQ-015 Priority SHALL be: memory wait > pcsrc_e flush > load-use stall. While mem_busy=1, flush_d, flush_e, and the load-use stall SHALL be held at 0. The E-stage hazards SHALL be re-evaluated after release.
REQ-016 Back-to-back accesses SHALL each be serviced: a new mem_req_m seen in IDLE directly after DONE SHALL start a new wait.
REQ-017 Outside the conditions above, all stall and flush outputs SHALL be 0.

Reset
REQ-018 While reset=1, all stall outputs SHALL be 0 and mem_busy SHALL be 0.
REQ-019 While reset=1, flush_d, flush_e, and flush_w SHALL be 1, and forward_ae and forward_be SHALL be 00.
REQ-020 At the first clk edge with reset=1, the FSM SHALL go to IDLE, cnt SHALL be set to 0, and the counters SHALL be cleared. A reset during WAIT SHALL abort the wait, and no stall SHALL persist into the first post-reset cycle.

Configuration
REQ-021 Macro HAZARD_PERF_CNT_EN SHALL control the performance counters.
  With the macro defined: stall_cnt SHALL increment on every cycle with stall_f=1, and flush_cnt SHALL increment on every cycle with flush_d|flush_e=1. Both SHALL saturate at all-ones.
  Without the macro: the ports and their logic SHALL be absent.

Verification
REQ-022 Forwarding test: rd_m=rd_w=rs1_e=5, regwrite_m=regwrite_w=1 -> forward_ae=10. Then regwrite_m=0 -> forward_ae=01. Then rd_m=rd_w=0 -> forward_ae=00.
REQ-023 Load-use test: load_e=1, rd_e=3, rs2_d=3 -> exactly one cycle of stall_f=stall_d=flush_e=1. With rd_e=0 -> no stall.
REQ-024 Branch-over-load test: pcsrc_e=1 together with a load-use match -> flush_d=flush_e=1 and stall_f=0.
REQ-025 Memory-wait test: MEM_LAT=3, mem_req_m held at 1 -> mem_busy high for exactly 3 cycles, then 1 cycle low (DONE), then 3 cycles high again. Additionally, pcsrc_e=1 during the wait -> flush_d=0.
REQ-026 Reset test: MEM_LAT=4, reset asserted on the 2nd wait cycle -> all stalls 0 in the cycle after reset deasserts, and the FSM in IDLE.
REQ-027 Counter test: with HAZARD_PERF_CNT_EN and CNT_W=4, apply 20 stall cycles -> stall_cnt=15 (saturated).
